// File: rtl/abc_driver.sv
// abc_driver: sequences one ABC root-finding request at a time.
// Latches operands from an active-low valid/ready upstream port, runs the
// soc/eoc handshake with the ABC unit under a per-phase timeout, and presents
// the result (or an error) on an active-low valid/ack downstream port.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | rfd=1, waiting for dav_=0 while the ABC unit is free (eoc=1)
//   START   | soc=1, waiting for the ABC unit to drop eoc
//   WAIT    | soc=0, ABC unit converting, waiting for eoc to rise
//   PRESENT | out_dav_=0, result held until downstream pulls out_rfd low
//   RELEASE | waiting for both out_rfd and dav_ to return high
module abc_driver #(
  parameter int TIMEOUT = 1023
) (
  input  logic       clock,
  input  logic       reset_,
  input  logic       dav_,
  output logic       rfd,
  input  logic [9:0] b_in,
  input  logic [9:0] c_in,
  input  logic [7:0] l_in,
  input  logic [7:0] r_in,
  output logic       soc,
  input  logic       eoc,
  output logic [9:0] b,
  output logic [9:0] c,
  output logic [7:0] l_0,
  output logic [7:0] r_0,
  input  logic [7:0] x_0,
  output logic [7:0] x,
  output logic       err,
  output logic       out_dav_,
  input  logic       out_rfd,
  output logic [7:0] count
);

  // Wide enough to hold TIMEOUT itself, never narrower than 11 bits.
  localparam int TW = ($clog2(TIMEOUT + 2) > 11) ? $clog2(TIMEOUT + 2) : 11;
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_inc;
  logic          accept;
  logic          degenerate;
  logic          tmo_hit;
  logic          in_start;
  logic          in_wait;

  assign in_start   = (state == S_START);
  assign in_wait    = (state == S_WAIT);
  // A request is only taken in IDLE and only while the ABC unit reports idle.
  assign accept     = (state == S_IDLE) && !dav_ && eoc;
  // An empty or inverted interval has no root to search for.
  assign degenerate = (l_in >= r_in);
  assign tmo_inc    = tmo_cnt + 1'b1;
  // Abort on the edge where the phase counter would reach TIMEOUT.
  assign tmo_hit    = (tmo_inc == TMO_LIMIT);

  // Handshake outputs decode from the state register only, so reset acts on
  // them at once and no input reaches an output combinationally.
  assign rfd      = (state == S_IDLE);
  assign soc      = in_start;
  assign out_dav_ = (state != S_PRESENT);

  // Next-state selection for the request/convert/present sequence.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = degenerate ? S_PRESENT : S_START;
        end
      end
      S_START: begin
        if (!eoc) begin
          state_nxt = S_WAIT;
        end else if (tmo_hit) begin
          state_nxt = S_PRESENT;
        end
      end
      S_WAIT: begin
        if (eoc || tmo_hit) begin
          state_nxt = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (!out_rfd) begin
          state_nxt = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (out_rfd && dav_) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand registers feeding the ABC unit, held from one accept to the next.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      b   <= '0;
      c   <= '0;
      l_0 <= '0;
      r_0 <= '0;
    end else if (accept) begin
      b   <= b_in;
      c   <= c_in;
      l_0 <= l_in;
      r_0 <= r_in;
    end
  end

  // Per-phase timeout counter: restarts on accept and on START->WAIT.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      tmo_cnt <= '0;
    end else if (accept) begin
      tmo_cnt <= '0;
    end else if (in_start && !eoc) begin
      tmo_cnt <= '0;
    end else if (in_start || in_wait) begin
      tmo_cnt <= tmo_inc;
    end
  end

  // Result registers; only updated on the transition into PRESENT.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      x     <= '0;
      err   <= 1'b0;
      count <= '0;
    end else if (accept && degenerate) begin
      x   <= '0;
      err <= 1'b1;
    end else if (in_start && eoc && tmo_hit) begin
      x   <= '0;
      err <= 1'b1;
    end else if (in_wait && eoc) begin
      x     <= x_0;
      err   <= 1'b0;
      count <= count + 8'd1;
    end else if (in_wait && tmo_hit) begin
      x   <= '0;
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_abc_driver.sv
// Bench for abc_driver with a behavioural ABC unit and a result scoreboard.
module tb_abc_driver;

  localparam int TMO = 15;

  logic       clock;
  logic       reset_;
  logic       dav_;
  logic       rfd;
  logic [9:0] b_in, c_in;
  logic [7:0] l_in, r_in;
  logic       soc;
  logic       eoc;
  logic [9:0] b, c;
  logic [7:0] l_0, r_0;
  logic [7:0] x_0;
  logic [7:0] x;
  logic       err;
  logic       out_dav_;
  logic       out_rfd;
  logic [7:0] count;

  typedef struct {
    logic [7:0] x;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_count = 8'd0;
  int         abc_mode = 0;   // 0 normal, 1 eoc stuck 1, 2 eoc stuck 0, 3 never finishes
  int         abc_lat = 3;
  int         soc_total = 0;

  abc_driver #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset_(reset_), .dav_(dav_), .rfd(rfd),
    .b_in(b_in), .c_in(c_in), .l_in(l_in), .r_in(r_in),
    .soc(soc), .eoc(eoc), .b(b), .c(c), .l_0(l_0), .r_0(r_0),
    .x_0(x_0), .x(x), .err(err), .out_dav_(out_dav_),
    .out_rfd(out_rfd), .count(count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Smallest x in [l,r] with x^2 - b*x - c >= 0.
  function automatic logic [7:0] root_of(input logic [9:0] bb, input logic [9:0] cc,
                                         input logic [7:0] ll, input logic [7:0] rr);
    int f;
    for (int i = int'(ll); i <= int'(rr); i++) begin
      f = i * i - int'(bb) * i - int'(cc);
      if (f >= 0) return 8'(i);
    end
    return rr;
  endfunction

  // Behavioural ABC unit.
  initial begin
    logic [7:0] mx;
    eoc = 1'b1;
    x_0 = 8'd0;
    forever begin
      @(posedge clock);
      #1;
      case (abc_mode)
        1: eoc = 1'b1;
        2: eoc = 1'b0;
        3: if (soc && eoc) eoc = 1'b0;
        default: begin
          if (!eoc) begin
            eoc = 1'b1;
          end else if (soc) begin
            eoc = 1'b0;
            mx  = root_of(b, c, l_0, r_0);
            x_0 = ~mx;
            repeat (abc_lat) @(posedge clock);
            #1;
            x_0 = mx;
            eoc = 1'b1;
          end
        end
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      if (soc === 1'b1) soc_total++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [9:0] bb, input logic [9:0] cc,
                      input logic [7:0] ll, input logic [7:0] rr);
    int n;
    n = 0;
    while (rfd !== 1'b1 && n < 200) begin @(negedge clock); n++; end
    if (rfd !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL send_rfd: rfd=%b, required 1", rfd);
      return;
    end
    b_in = bb; c_in = cc; l_in = ll; r_in = rr;
    dav_ = 1'b0;
    n = 0;
    while (rfd !== 1'b0 && n < 200) begin @(negedge clock); n++; end
    if (rfd !== 1'b0) begin
      n_cmp++; n_bad++;
      $display("FAIL send_accept: rfd=%b, required 0", rfd);
    end
    dav_ = 1'b1;
  endtask

  task automatic recv(input string name);
    exp_t e;
    int   n;
    n = 0;
    while (out_dav_ !== 1'b0 && n < 200) begin @(negedge clock); n++; end
    if (out_dav_ !== 1'b0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_valid: out_dav_=%b, required 0", name, out_dav_);
      return;
    end
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_sb: unexpected result x=%0d err=%b, required none", name, x, err);
      return;
    end
    e = sb.pop_front();
    if (!e.err) exp_count = exp_count + 8'd1;
    n_cmp++;
    if (x !== e.x) begin n_bad++; $display("FAIL %s_x: got %0d, required %0d", name, x, e.x); end
    n_cmp++;
    if (err !== e.err) begin n_bad++; $display("FAIL %s_err: got %b, required %b", name, err, e.err); end
    n_cmp++;
    if (count !== exp_count) begin n_bad++; $display("FAIL %s_count: got %0d, required %0d", name, count, exp_count); end
    out_rfd = 1'b0;
    @(negedge clock);
    n = 0;
    while (out_dav_ !== 1'b1 && n < 50) begin @(negedge clock); n++; end
    if (out_dav_ !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_ack: out_dav_=%b, required 1", name, out_dav_);
    end
    out_rfd = 1'b1;
  endtask

  task automatic test_reset();
    reset_ = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({rfd, soc, out_dav_, err} !== 4'b1010) begin
      n_bad++; $display("FAIL reset_ctl: rfd/soc/out_dav_/err=%b, required 1010", {rfd, soc, out_dav_, err});
    end
    n_cmp++;
    if (x !== 8'd0 || count !== 8'd0) begin
      n_bad++; $display("FAIL reset_res: x=%0d count=%0d, required 0 0", x, count);
    end
    n_cmp++;
    if ({b, c, l_0, r_0} !== 36'd0) begin
      n_bad++; $display("FAIL reset_ops: %h, required 0", {b, c, l_0, r_0});
    end
    reset_ = 1'b1;
    exp_count = 8'd0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    int s0;
    s0 = soc_total;
    sb.push_back('{x: 8'd10, err: 1'b0});
    send(10'd10, 10'd0, 8'd5, 8'd20);
    recv("basic");
    n_cmp++;
    if (soc_total - s0 != 1) begin
      n_bad++; $display("FAIL basic_soc: soc high %0d cycles, required 1", soc_total - s0);
    end
    n_cmp++;
    if ({b, c, l_0, r_0} !== {10'd10, 10'd0, 8'd5, 8'd20}) begin
      n_bad++; $display("FAIL basic_ops: %h, required operands 10/0/5/20", {b, c, l_0, r_0});
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n;
    sb.push_back('{x: 8'd7, err: 1'b0});
    send(10'd0, 10'd49, 8'd0, 8'd100);
    @(negedge clock);
    b_in = 10'd10; c_in = 10'd0; l_in = 8'd5; r_in = 8'd20;
    dav_ = 1'b0;
    n = 0;
    while (out_dav_ !== 1'b0 && n < 200) begin @(negedge clock); n++; end
    n_cmp++;
    if (out_dav_ !== 1'b0) begin n_bad++; $display("FAIL b2b_valid: out_dav_=%b, required 0", out_dav_); end
    n_cmp++;
    if (rfd !== 1'b0 || b !== 10'd0 || c !== 10'd49) begin
      n_bad++; $display("FAIL b2b_hold: rfd=%b b=%0d c=%0d, required 0 0 49", rfd, b, c);
    end
    e = sb.pop_front();
    exp_count = exp_count + 8'd1;
    n_cmp++;
    if (x !== e.x || err !== e.err) begin
      n_bad++; $display("FAIL b2b_first: x=%0d err=%b, required %0d %b", x, err, e.x, e.err);
    end
    out_rfd = 1'b0;
    @(negedge clock);
    out_rfd = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (rfd !== 1'b0 || out_dav_ !== 1'b1) begin
      n_bad++; $display("FAIL b2b_release: rfd=%b out_dav_=%b, required 0 1", rfd, out_dav_);
    end
    dav_ = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (rfd !== 1'b1) begin n_bad++; $display("FAIL b2b_idle: rfd=%b, required 1", rfd); end
    sb.push_back('{x: 8'd10, err: 1'b0});
    send(10'd10, 10'd0, 8'd5, 8'd20);
    n_cmp++;
    if (b !== 10'd10) begin n_bad++; $display("FAIL b2b_latch: b=%0d, required 10", b); end
    recv("b2b_second");
  endtask

  task automatic test_degenerate();
    int s0;
    int n;
    s0 = soc_total;
    while (rfd !== 1'b1) @(negedge clock);
    b_in = 10'd3; c_in = 10'd3; l_in = 8'd30; r_in = 8'd30;
    dav_ = 1'b0;
    n = 0;
    while (out_dav_ !== 1'b0 && n < 2) begin @(negedge clock); n++; end
    dav_ = 1'b1;
    n_cmp++;
    if (out_dav_ !== 1'b0) begin
      n_bad++; $display("FAIL degen_latency: out_dav_=%b after 2 clocks, required 0", out_dav_);
    end
    sb.push_back('{x: 8'd0, err: 1'b1});
    recv("degen");
    n_cmp++;
    if (soc_total != s0) begin
      n_bad++; $display("FAIL degen_soc: soc high %0d cycles, required 0", soc_total - s0);
    end
  endtask

  task automatic test_start_timeout();
    int s0;
    abc_mode = 1;
    repeat (2) @(negedge clock);
    s0 = soc_total;
    sb.push_back('{x: 8'd0, err: 1'b1});
    send(10'd10, 10'd0, 8'd5, 8'd20);
    recv("tmo_start");
    n_cmp++;
    if (soc_total - s0 != TMO) begin
      n_bad++; $display("FAIL tmo_start_soc: soc high %0d cycles, required %0d", soc_total - s0, TMO);
    end
    abc_mode = 0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_wait_timeout();
    int s0;
    abc_mode = 3;
    s0 = soc_total;
    sb.push_back('{x: 8'd0, err: 1'b1});
    send(10'd0, 10'd49, 8'd0, 8'd100);
    recv("tmo_wait");
    n_cmp++;
    if (soc_total - s0 != 1) begin
      n_bad++; $display("FAIL tmo_wait_soc: soc high %0d cycles, required 1", soc_total - s0);
    end
    abc_mode = 0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset_mid_op();
    // Reset while soc is high must drop it asynchronously.
    abc_mode = 1;
    send(10'd10, 10'd0, 8'd5, 8'd20);
    n_cmp++;
    if (soc !== 1'b1) begin n_bad++; $display("FAIL rst_start_pre: soc=%b, required 1", soc); end
    #1 reset_ = 1'b0;
    #1;
    n_cmp++;
    if ({soc, rfd, out_dav_} !== 3'b011) begin
      n_bad++; $display("FAIL rst_start: soc/rfd/out_dav_=%b, required 011", {soc, rfd, out_dav_});
    end
    @(negedge clock);
    reset_ = 1'b1;
    abc_mode = 0;
    repeat (3) @(negedge clock);
    // Reset while the ABC unit is converting.
    abc_lat = 6;
    send(10'd0, 10'd49, 8'd0, 8'd100);
    @(negedge clock);
    #1 reset_ = 1'b0;
    #1;
    n_cmp++;
    if ({soc, rfd, out_dav_} !== 3'b011) begin
      n_bad++; $display("FAIL rst_wait: soc/rfd/out_dav_=%b, required 011", {soc, rfd, out_dav_});
    end
    n_cmp++;
    if (count !== 8'd0 || err !== 1'b0 || b !== 10'd0) begin
      n_bad++; $display("FAIL rst_wait_res: count=%0d err=%b b=%0d, required 0 0 0", count, err, b);
    end
    exp_count = 8'd0;
    @(negedge clock);
    reset_ = 1'b1;
    repeat (10) @(negedge clock);
    abc_lat = 3;
  endtask

  task automatic test_busy_after_reset();
    abc_mode = 2;
    repeat (2) @(negedge clock);
    b_in = 10'd10; c_in = 10'd0; l_in = 8'd5; r_in = 8'd20;
    dav_ = 1'b0;
    repeat (5) @(negedge clock);
    n_cmp++;
    if (rfd !== 1'b1 || b !== 10'd0) begin
      n_bad++; $display("FAIL busy_reject: rfd=%b b=%0d, required 1 0", rfd, b);
    end
    abc_mode = 0;
    sb.push_back('{x: 8'd10, err: 1'b0});
    send(10'd10, 10'd0, 8'd5, 8'd20);
    recv("busy_then_ok");
  endtask

  task automatic test_count_wrap();
    logic [9:0] bb, cc;
    logic [7:0] ll, rr;
    reset_ = 1'b0;
    @(negedge clock);
    reset_ = 1'b1;
    exp_count = 8'd0;
    @(negedge clock);
    for (int i = 0; i < 256; i++) begin
      bb = 10'($urandom_range(0, 1023));
      cc = 10'($urandom_range(0, 1023));
      ll = 8'($urandom_range(0, 200));
      rr = 8'($urandom_range(int'(ll) + 1, 255));
      sb.push_back('{x: root_of(bb, cc, ll, rr), err: 1'b0});
      send(bb, cc, ll, rr);
      recv("wrap");
    end
    n_cmp++;
    if (count !== 8'd0) begin
      n_bad++; $display("FAIL wrap_final: count=%0d, required 0", count);
    end
  endtask

  initial begin
    reset_  = 1'b0;
    dav_    = 1'b1;
    out_rfd = 1'b1;
    b_in = '0; c_in = '0; l_in = '0; r_in = '0;
    @(negedge clock);
    test_reset();
    test_basic();
    test_back_to_back();
    test_degenerate();
    test_start_timeout();
    test_wait_timeout();
    test_reset_mid_op();
    test_busy_after_reset();
    test_count_wrap();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL sb_drain: %0d results outstanding, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/abc_driver.md
ABC_DRIVER -- requirements
Module: abc_driver

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, meaning max clocks allowed per ABC handshake phase before abort.
REQ-002 SHALL have port clock  input  1  system clock, all state changes on rising edge.
REQ-003 SHALL have port reset_  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port dav_  input  1  upstream operands valid, active-low.
REQ-005 SHALL have port rfd  output  1  ready for upstream data.
REQ-006 SHALL have port b_in, c_in  input  10 each  quadratic coefficients of f(x)=x^2-b*x-c.
REQ-007 SHALL have port l_in, r_in  input  8 each  initial bisection interval [l,r].
REQ-008 SHALL have port soc  output  1  start-of-conversion to ABC unit.
REQ-009 SHALL have port eoc  input  1  end-of-conversion from ABC unit.
REQ-010 SHALL have port b, c  output  10 each  and l_0, r_0  output  8 each  registered operands driven to ABC unit.
REQ-011 SHALL have port x_0  input  8  root returned by ABC unit.
REQ-012 SHALL have port x  output  8  result to downstream; err  output  1  result invalid.
REQ-013 SHALL have port out_dav_  output  1  result valid, active-low; out_rfd  input  1  downstream ready/acknowledge.
REQ-014 SHALL have port count  output  8  number of successful conversions, modulo 256.

Function
REQ-015 SHALL implement FSM states IDLE, START, WAIT, PRESENT, RELEASE.
REQ-016 IDLE: rfd=1; on clock with dav_=0 and eoc=1, SHALL latch b_in/c_in/l_in/r_in into b/c/l_0/r_0, set rfd=0.
REQ-017 IDLE with dav_=0 and eoc=0 SHALL NOT accept (ABC busy); rfd stays 1, no latch.
REQ-018 On accept, if l_in >= r_in SHALL skip ABC: x=0, err=1, go PRESENT; soc never asserted.
REQ-019 On accept with l_in < r_in SHALL go START, soc=1, clear timeout counter.
REQ-020 START: hold soc=1 until eoc sampled 0, then soc=0, clear timeout counter, go WAIT.
REQ-021 WAIT: soc=0; on eoc sampled 1, SHALL register x=x_0, err=0, increment count (255 wraps to 0), go PRESENT.
REQ-022 Timeout counter SHALL be at least 11 bits (TIMEOUT+1 representable), increments each cycle in START/WAIT.
REQ-023 Counter reaching TIMEOUT in START or WAIT SHALL force soc=0, x=0, err=1, go PRESENT; count unchanged.
REQ-024 PRESENT: out_dav_=0 with x/err stable; on out_rfd sampled 0, out_dav_=1, go RELEASE.
REQ-025 RELEASE: go IDLE (rfd=1) only when out_rfd=1 and dav_=1 both sampled; otherwise stay.
REQ-026 b/c/l_0/r_0 SHALL remain stable from accept until next accept.
REQ-027 Minimum latency from accept to out_dav_=0 SHALL be ABC latency + 2 clocks; no combinational path input->output.
REQ-028 dav_ returning high before RELEASE SHALL be ignored; a new request is never accepted outside IDLE.

Reset
REQ-029 reset_=0 SHALL immediately force IDLE, rfd=1, soc=0, out_dav_=1, x=0, err=0, count=0, b=c=l_0=r_0=0, timeout counter=0.
REQ-030 Reset mid-operation (any state) SHALL abort without result; soc drops at once, no count change.
REQ-031 After reset release, first accept SHALL still require eoc=1.

Verification
REQ-032 Behavioural ABC model, b=10,c=0,l=5,r=20 -> soc pulse, x=10, err=0, count=1.
REQ-033 b=0,c=49,l=0,r=100 -> x=7, err=0; back-to-back second request accepted only after RELEASE.
REQ-034 l=30,r=30 -> soc never 1, x=0, err=1, out_dav_=0 within 2 clocks, count unchanged.
REQ-035 Model ignores soc (eoc stuck 1), TIMEOUT=15 -> soc drops after 15 clocks in START, err=1, x=0.
REQ-036 256 successful conversions -> count returns 0; reset_=0 during WAIT -> soc=0, rfd=1, out_dav_=1 same cycle.
